// File: rtl/text_buffer.sv
// text_buffer: ROWS x COLS character-cell store with a registered read port and a
// cell-per-clock screen clear. Writes that arrive while a clear is running are parked
// in a single pending slot and committed once the sweep finishes.
module text_buffer #(
  parameter int COLS   = 20,
  parameter int ROWS   = 7,
  parameter int CODE_W = 8,
  parameter int BLANK  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [3:0]        wr_row,
  input  logic [5:0]        wr_col,
  input  logic              clr,
  input  logic              page,
  input  logic [3:0]        rd_row,
  input  logic [5:0]        rd_col,
  output logic [CODE_W-1:0] rd_data,
  output logic              busy,
  output logic              overrun
);

  localparam int                DEPTH      = ROWS * COLS;
  localparam logic [7:0]        LAST_CELL  = 8'(DEPTH - 1);
  localparam logic [3:0]        ROW_LIM    = 4'(ROWS);
  localparam logic [5:0]        COL_LIM    = 6'(COLS);
  localparam logic [7:0]        COLS_8     = 8'(COLS);
  localparam logic [CODE_W-1:0] BLANK_CODE = CODE_W'(BLANK);
  // All-ones code is reserved by the feeder as its clear marker and never stored.
  localparam logic [CODE_W-1:0] MARKER     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN
  } state_t;

  state_t            state_q;
  logic [7:0]        clr_addr_q;
  logic              pend_v_q;
  logic [7:0]        pend_addr_q;
  logic [CODE_W-1:0] pend_code_q;
  logic              overrun_q;

  logic [CODE_W-1:0] ram [DEPTH];
  logic [CODE_W-1:0] ram_rd_q;
  logic              rd_blank_q;

  logic              clear_req;
  logic              wr_ok;
  logic              rd_in_range;
  logic [7:0]        wr_addr;
  logic [7:0]        rd_addr;
  logic [7:0]        rd_addr_safe;

  logic              ram_we;
  logic [7:0]        ram_waddr;
  logic [CODE_W-1:0] ram_wdata;

  // clr and page are the same request seen from two feeder outputs.
  assign clear_req = clr | page;

  // Linear addresses wrap in 8 bits; they are only used when the row/col are in range.
  assign wr_addr      = {4'd0, wr_row} * COLS_8 + {2'd0, wr_col};
  assign rd_addr      = {4'd0, rd_row} * COLS_8 + {2'd0, rd_col};
  assign rd_in_range  = (rd_row < ROW_LIM) && (rd_col < COL_LIM);
  assign rd_addr_safe = rd_in_range ? rd_addr : 8'd0;
  assign wr_ok        = wr_en && (wr_row < ROW_LIM) && (wr_col < COL_LIM) && (wr_code != MARKER);

  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;
  assign rd_data = rd_blank_q ? BLANK_CODE : ram_rd_q;

  // Control FSM: clear sweep, pending-slot capture and drain; a clear request restarts everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_addr_q  <= 8'd0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 8'd0;
      pend_code_q <= '0;
      overrun_q   <= 1'b0;
    end else if (clear_req) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= 8'd0;
      pend_v_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_CLEAR: begin
          if (wr_ok) begin
            pend_v_q    <= 1'b1;
            pend_addr_q <= wr_addr;
            pend_code_q <= wr_code;
            if (pend_v_q) overrun_q <= 1'b1;
          end
          if (clr_addr_q == LAST_CELL) begin
            clr_addr_q <= 8'd0;
            // A write captured on the final sweep cycle must still be drained.
            state_q    <= (pend_v_q || wr_ok) ? S_DRAIN : S_IDLE;
          end else begin
            clr_addr_q <= clr_addr_q + 8'd1;
          end
        end
        S_DRAIN: begin
          if (wr_ok) begin
            pend_addr_q <= wr_addr;
            pend_code_q <= wr_code;
          end else begin
            pend_v_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Single RAM write port shared by idle writes, the clear sweep and the drain.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_code;
    if (!reset && !clear_req) begin
      case (state_q)
        S_IDLE:  ram_we = wr_ok;
        S_CLEAR: begin
          ram_we    = 1'b1;
          ram_waddr = clr_addr_q;
          ram_wdata = BLANK_CODE;
        end
        S_DRAIN: begin
          ram_we    = 1'b1;
          ram_waddr = pend_addr_q;
          ram_wdata = pend_code_q;
        end
        default: ram_we = 1'b0;
      endcase
    end
  end

  // Block RAM: read-before-write, so a same-cell read and write returns the old contents.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rd_q <= ram[rd_addr_safe];
  end

  // Output blanking flag, registered alongside the RAM read to keep latency at one cycle.
  always_ff @(posedge clk) begin
    if (reset) rd_blank_q <= 1'b1;
    else       rd_blank_q <= busy || !rd_in_range;
  end

endmodule
